imem_prog_loader: RTL and testbench
===================================

// Module: imem_prog_loader
// PURPOSE
//  Writer side of the instruction memory that the processor's fetch block reads.
//  Accepts a program as a byte stream over a valid/ready handshake and writes it into
//  the instruction memory write port.
//  Pads unused locations with PAD_WORD and holds the core in reset until the image is complete.
//  Sits between the test/host interface and the instruction memory plus the processor reset input.
// PARAMETERS
//  INSTR_W   8     instruction width; matches the 8-bit instruction word
//  ADDR_W    6     instruction address width; matches the 6-bit branch target field
//  DEPTH     64    memory words; must equal 2**ADDR_W
//  PAD_WORD  8'h00 value written to every location after the last program byte
// PORTS
//  clk          in   1         single clock; all state updates on rising edge
//  reset        in   1         asynchronous, active-high
//  load_req     in   1         start (re)load; sampled only in IDLE and RUN
//  in_valid     in   1         program byte valid
//  in_data      in   INSTR_W   program byte
//  in_last      in   1         marks final byte of program
//  in_ready     out  1         loader accepts a byte this cycle
//  mem_we       out  1         instruction memory write enable (registered)
//  mem_addr     out  ADDR_W    write address (registered)
//  mem_wdata    out  INSTR_W   write data (registered)
//  core_reset   out  1         drives processor reset; 1 = hold core
//  load_done    out  1         image complete, core running
//  prog_len     out  ADDR_W+1  number of stream bytes stored, 1..DEPTH
//  err_overflow out  1         stream exceeded DEPTH bytes; sticky until next load_req
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0,
//    core_reset=1, load_done=0, prog_len=0, err_overflow=0, word counter cnt=0.
//  States: IDLE, LOAD, FILL, DRAIN, RUN.
//  IDLE: in_ready=0; load_req=1 -> LOAD, cnt=0, err_overflow=0.
//  LOAD: in_ready=1, decoded combinationally from state only.
//    Transfer = in_valid & in_ready.
//    On each transfer, next cycle mem_we=1, mem_addr=cnt, mem_wdata=in_data (1-cycle latency).
//    Then cnt++ and prog_len=cnt+1.
//    No transfer -> mem_we=0 next cycle; never a duplicate or skipped address.
//    Transfer with in_last at cnt<DEPTH-1 -> FILL.
//    Transfer at cnt==DEPTH-1 with in_last -> RUN (no fill).
//    Transfer at cnt==DEPTH-1 without in_last -> err_overflow=1, then DRAIN.
//  FILL: in_ready=0; one write per cycle of PAD_WORD at successive addresses through DEPTH-1.
//    After the DEPTH-1 write -> RUN.
//  DRAIN: in_ready=1; bytes accepted and discarded, mem_we=0; transfer with in_last -> RUN.
//  RUN entry: core_reset=0 and load_done=1, asserted in the cycle after the final mem_we pulse.
//    The core therefore never fetches before the last write lands.
//  RUN: in_ready=0; load_req=1 -> LOAD with core_reset=1 and load_done=0 on the same edge.
//    prog_len holds until the first new transfer.
//  load_req in LOAD/FILL/DRAIN: ignored.
//  in_valid outside LOAD/DRAIN: ignored; source must hold in_data/in_last while in_valid & !in_ready.
//  cnt is ADDR_W bits and never wraps: the terminal checks above act first.
//    Every load writes exactly DEPTH words.
//  Reset mid-load: abandon the image, outputs return to reset values.
//    The memory contents are undefined to the core until the next full load.
// STRUCTURE
//  Shared include proc_defs.vh: INSTR_W, ADDR_W, DEPTH, loader state encodings; the processor
//    side uses the same INSTR_W/ADDR_W.
//  One module: FSM + cnt + registered write stage.
//  The write stage may be split out as sub-module imem_wr_stage (registers we/addr/wdata).
// TESTING
//  T1 reset asserted mid-cycle -> all outputs at reset values immediately; core_reset=1, in_ready=0.
//  T2 load_req, bytes A1,B2,C3 (last on C3) -> writes 0:A1 1:B2 2:C3, addrs 3..63=00.
//    core_reset falls the cycle after the addr-63 write; prog_len=3.
//  T3 same stream with in_valid gaps of 0..3 cycles -> identical write sequence, no duplicates.
//  T4 exactly 64 bytes, last on 64th -> no FILL, err_overflow=0, prog_len=64, RUN.
//  T5 66 bytes, last on 66th -> 64 written, bytes 65-66 not written, err_overflow=1, prog_len=64.
//  T6 reset after 10 bytes, then a new load of 2 bytes -> writes start at addr 0.
//    load_req in RUN -> core_reset=1 on the same edge, then a full reload.

Source files
------------

// File: rtl/imem_prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// INSTR_W/ADDR_W are the same widths the processor fetch side uses.
package imem_prog_loader_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned LEN_W   = ADDR_W + 1;

    localparam logic [INSTR_W-1:0] PAD_WORD  = INSTR_W'(8'h00);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Loader state encodings
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4
    } ld_state_t;

    // One instruction-memory write request
    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] wdata;
    } wr_req_t;

    // Number of stored bytes once the word at address c has been written
    function automatic logic [LEN_W-1:0] len_from_cnt(input logic [ADDR_W-1:0] c);
        return LEN_W'(c) + LEN_W'(1);
    endfunction

endpackage

// File: rtl/imem_prog_loader_wr_stage.sv
// Registered write stage driving the instruction memory write port.
// Ports:
//   clk, reset          clock, async active-high reset
//   req                 write request from the loader FSM (this cycle)
//   mem_we/addr/wdata   registered memory write port (one cycle later)
module imem_prog_loader_wr_stage
    import imem_prog_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  wr_req_t            req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata
);

    // Address/data only move on a write so the bus is quiet between writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= req.we;
            if (req.we) begin
                mem_addr  <= req.addr;
                mem_wdata <= req.wdata;
            end
        end
    end

endmodule

// File: rtl/imem_prog_loader.sv
// Instruction memory program loader: receives a program byte stream over
// valid/ready, writes it to the instruction memory, pads the remaining words
// with PAD_WORD and holds the core in reset until the whole image is written.
// Ports:
//   clk, reset                    clock, async active-high reset
//   load_req                      start a (re)load, honoured in IDLE and RUN
//   in_valid/in_data/in_last      program byte stream
//   in_ready                      byte accepted this cycle (LOAD, DRAIN)
//   mem_we/mem_addr/mem_wdata     registered instruction memory write port
//   core_reset                    1 = processor held in reset
//   load_done                     image complete, core running
//   prog_len                      stream bytes stored (1..DEPTH)
//   err_overflow                  stream longer than DEPTH, sticky until load_req
module imem_prog_loader
    import imem_prog_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_req,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               core_reset,
    output logic               load_done,
    output logic [LEN_W-1:0]   prog_len,
    output logic               err_overflow
);

    ld_state_t         state;
    logic [ADDR_W-1:0] cnt;
    logic              xfer;
    logic              at_last;
    wr_req_t           wr_req;

    // Ready depends on state only, so it never combinationally follows in_valid
    assign in_ready = (state == ST_LOAD) || (state == ST_DRAIN);
    assign xfer     = in_valid & in_ready;
    assign at_last  = (cnt == LAST_ADDR);

    // Write request: stream bytes in LOAD, pad words in FILL
    always_comb begin
        wr_req = '0;
        case (state)
            ST_LOAD: begin
                if (xfer) begin
                    wr_req.we    = 1'b1;
                    wr_req.addr  = cnt;
                    wr_req.wdata = in_data;
                end
            end
            ST_FILL: begin
                wr_req.we    = 1'b1;
                wr_req.addr  = cnt;
                wr_req.wdata = PAD_WORD;
            end
            default: ;
        endcase
    end

    // Loader FSM, word counter and status outputs.
    // cnt stops at LAST_ADDR; the terminal checks fire before it could wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            core_reset   <= 1'b1;
            load_done    <= 1'b0;
            prog_len     <= '0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        state        <= ST_LOAD;
                        cnt          <= '0;
                        err_overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        prog_len <= len_from_cnt(cnt);
                        if (at_last) begin
                            if (in_last) begin
                                state <= ST_RUN;
                            end else begin
                                err_overflow <= 1'b1;
                                state        <= ST_DRAIN;
                            end
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                            if (in_last) begin
                                state <= ST_FILL;
                            end
                        end
                    end
                end
                ST_FILL: begin
                    if (at_last) begin
                        state <= ST_RUN;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (xfer && in_last) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Release is one edge after RUN entry, i.e. the cycle after
                    // the final write pulse is on the memory port.
                    if (load_req) begin
                        state        <= ST_LOAD;
                        cnt          <= '0;
                        err_overflow <= 1'b0;
                        core_reset   <= 1'b1;
                        load_done    <= 1'b0;
                    end else begin
                        core_reset <= 1'b0;
                        load_done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    imem_prog_loader_wr_stage u_wr_stage (
        .clk       (clk),
        .reset     (reset),
        .req       (wr_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: table of stream loads plus hand-written
// reset-mid-load and load_req-during-load sequences. Expected memory writes
// are queued as bytes are driven and popped as mem_we pulses appear.
module tb_imem_prog_loader;

    logic       clk;
    logic       reset;
    logic       load_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_reset;
    logic       load_done;
    logic [6:0] prog_len;
    logic       err_overflow;

    imem_prog_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .prog_len     (prog_len),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        int n_bytes;
        int max_gap;
        int exp_len;
        bit exp_err;
    } vec_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  last_we_cyc = -1;
    int  fall_cyc    = -1;
    logic prev_cr = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_val(input int i);
        logic [7:0] b;
        b = 8'(i * 17);
        return 8'hA1 + b;
    endfunction

    // Write monitor / scoreboard consumer
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!reset) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(mem_addr), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.a));
                    chk("wr_data", 32'(mem_wdata), 32'(e.d));
                end
                chk("core_held_during_write", 32'(core_reset), 32'd1);
                last_we_cyc = cyc;
            end
            if (prev_cr && !core_reset) fall_cyc = cyc;
        end
        prev_cr = core_reset;
    end

    // Pulse load_req for one edge; core must be held on that same edge
    task automatic start_load();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk("core_reset_on_load", 32'(core_reset), 32'd1);
        chk("load_done_on_load", 32'(load_done), 32'd0);
        fall_cyc = -1;
    endtask

    // Drive bytes start..start+n-1; queue the writes they should cause
    task automatic send_stream(input int start, input int n, input bit with_last, input int max_gap);
        for (int i = start; i < start + n; i++) begin
            int  gap;
            int  w;
            bit  acc;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = byte_val(i);
            in_last  = with_last && (i == start + n - 1);
            if (i < 64) exp_q.push_back({6'(i), byte_val(i)});
            w = 0;
            acc = 1'b0;
            while (!acc && w < 100) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                w++;
            end
            if (!acc) chk("handshake_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        if (with_last) begin
            for (int a = start + n; a < 64; a++) exp_q.push_back({6'(a), 8'h00});
        end
    endtask

    task automatic wait_done_check(input string tag, input int exp_len, input bit exp_err);
        int w;
        w = 0;
        while (!load_done && w < 200) begin
            @(negedge clk); #1;
            w++;
        end
        chk({tag, "_load_done"}, 32'(load_done), 32'd1);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        chk({tag, "_prog_len"}, 32'(prog_len), 32'(exp_len));
        chk({tag, "_err_overflow"}, 32'(err_overflow), 32'(exp_err));
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        chk({tag, "_release_after_writes"}, 32'(fall_cyc > last_we_cyc), 32'd1);
        if (!exp_err) chk({tag, "_release_timing"}, 32'(fall_cyc), 32'(last_we_cyc + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{n_bytes: 3,  max_gap: 0, exp_len: 3,  exp_err: 1'b0};
        vecs[1] = '{n_bytes: 3,  max_gap: 3, exp_len: 3,  exp_err: 1'b0};
        vecs[2] = '{n_bytes: 64, max_gap: 0, exp_len: 64, exp_err: 1'b0};
        vecs[3] = '{n_bytes: 66, max_gap: 1, exp_len: 64, exp_err: 1'b1};
        vecs[4] = '{n_bytes: 63, max_gap: 0, exp_len: 63, exp_err: 1'b0};
        vecs[5] = '{n_bytes: 1,  max_gap: 2, exp_len: 1,  exp_err: 1'b0};

        reset    = 1'b1;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_prog_len", 32'(prog_len), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_core_reset", 32'(core_reset), 32'd1);

        // Table of loads; after the first, each load_req arrives in RUN
        for (int v = 0; v < 6; v++) begin
            start_load();
            send_stream(0, vecs[v].n_bytes, 1'b1, vecs[v].max_gap);
            wait_done_check($sformatf("vec%0d", v), vecs[v].exp_len, vecs[v].exp_err);
            repeat (2) begin @(posedge clk); #1; end
        end

        // Reset asserted mid-cycle after 10 bytes, then a fresh 2-byte load
        start_load();
        send_stream(0, 10, 1'b0, 0);
        @(negedge clk); #1;
        chk("midload_queue", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_mem_we", 32'(mem_we), 32'd0);
        chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mrst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("mrst_core_reset", 32'(core_reset), 32'd1);
        chk("mrst_load_done", 32'(load_done), 32'd0);
        chk("mrst_prog_len", 32'(prog_len), 32'd0);
        chk("mrst_err", 32'(err_overflow), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start_load();
        send_stream(0, 2, 1'b1, 0);
        wait_done_check("after_reset", 2, 1'b0);

        // load_req during LOAD is ignored: stream continues at the same address
        @(posedge clk); #1;
        start_load();
        send_stream(0, 5, 1'b0, 0);
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        send_stream(5, 3, 1'b1, 1);
        wait_done_check("ignore_req", 8, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
